// File: rtl/stack_pointer_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stack_pointer_unit                                              |
// | Purpose  : MSP/RSP owner; turns push/pop requests into 2-cycle memory ops   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module stack_pointer_unit #(
  parameter logic [15:0] MSP_TOP    = 16'd4095,
  parameter logic [15:0] RSP_TOP    = 16'd8191,
  parameter int unsigned MAIN_DEPTH = 1024,
  parameter int unsigned RET_DEPTH  = 512
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MainPush,
  input  logic        MainPop,
  input  logic        RetPush,
  input  logic        RetPop,
  input  logic        LoadMSP,
  input  logic [15:0] LoadValue,
  input  logic        ClearErr,
  output logic [15:0] MSP,
  output logic [15:0] RSP,
  output logic [15:0] MemDst1FromMSP,
  output logic [15:0] MemDst2FromMSP,
  output logic [15:0] MemDst2FromRSP,
  output logic [1:0]  MemDst1,
  output logic [1:0]  MemDst2,
  output logic        MemRead1,
  output logic        MemWrite2,
  output logic        Busy,
  output logic        Done,
  output logic        Overflow,
  output logic        Underflow,
  output logic        BadOp
);

  localparam logic [15:0] c_MAIN_FULL = MSP_TOP - 16'(MAIN_DEPTH);
  localparam logic [15:0] c_RET_FULL  = RSP_TOP - 16'(RET_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2} state_t;
  typedef enum logic [1:0] {OP_MPUSH = 2'd0, OP_MPOP = 2'd1, OP_RPUSH = 2'd2, OP_RPOP = 2'd3} op_t;

  state_t      r_state;
  op_t         r_op;
  logic [15:0] r_msp;
  logic [15:0] r_rsp;
  logic [1:0]  r_memDst1;
  logic [1:0]  r_memDst2;
  logic        r_memRead1;
  logic        r_memWrite2;
  logic        r_busy;
  logic        r_done;
  logic        r_overflow;
  logic        r_underflow;
  logic        r_badOp;

  logic [2:0]  w_reqCount;
  logic        w_mainFull;
  logic        w_mainEmpty;
  logic        w_retFull;
  logic        w_retEmpty;

  assign w_reqCount  = {2'b00, MainPush} + {2'b00, MainPop} + {2'b00, RetPush}
                     + {2'b00, RetPop} + {2'b00, LoadMSP};
  assign w_mainFull  = (r_msp == c_MAIN_FULL);
  assign w_mainEmpty = (r_msp == MSP_TOP);
  assign w_retFull   = (r_rsp == c_RET_FULL);
  assign w_retEmpty  = (r_rsp == RSP_TOP);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_op        <= OP_MPUSH;
      r_msp       <= MSP_TOP;
      r_rsp       <= RSP_TOP;
      r_memDst1   <= 2'd0;
      r_memDst2   <= 2'd0;
      r_memRead1  <= 1'b0;
      r_memWrite2 <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_badOp     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Clearing first lets an error detected on the same edge win.
      if (ClearErr) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
        r_badOp     <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_reqCount > 3'd1) begin
            r_badOp <= 1'b1;
          end else if (LoadMSP) begin
            r_msp  <= LoadValue;
            r_done <= 1'b1;
          end else if (MainPush) begin
            if (w_mainFull) begin
              r_overflow <= 1'b1;
            end else begin
              r_op        <= OP_MPUSH;
              r_state     <= ACC1;
              r_busy      <= 1'b1;
              r_memWrite2 <= 1'b1;
              r_memDst2   <= 2'd0;
            end
          end else if (RetPush) begin
            if (w_retFull) begin
              r_overflow <= 1'b1;
            end else begin
              r_op        <= OP_RPUSH;
              r_state     <= ACC1;
              r_busy      <= 1'b1;
              r_memWrite2 <= 1'b1;
              r_memDst2   <= 2'd1;
            end
          end else if (MainPop) begin
            if (w_mainEmpty) begin
              r_underflow <= 1'b1;
            end else begin
              r_op       <= OP_MPOP;
              r_state    <= ACC1;
              r_busy     <= 1'b1;
              r_memRead1 <= 1'b1;
              r_memDst1  <= 2'd1;
            end
          end else if (RetPop) begin
            if (w_retEmpty) begin
              r_underflow <= 1'b1;
            end else begin
              r_op       <= OP_RPOP;
              r_state    <= ACC1;
              r_busy     <= 1'b1;
              r_memRead1 <= 1'b1;
              r_memDst1  <= 2'd1;
            end
          end
        end
        ACC1: begin
          r_state <= ACC2;
          r_done  <= 1'b1;
        end
        ACC2: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_memRead1  <= 1'b0;
          r_memWrite2 <= 1'b0;
          r_memDst1   <= 2'd0;
          r_memDst2   <= 2'd0;
          case (r_op)
            OP_MPUSH: r_msp <= r_msp - 16'd1;
            OP_MPOP:  r_msp <= r_msp + 16'd1;
            OP_RPUSH: r_rsp <= r_rsp - 16'd1;
            default:  r_rsp <= r_rsp + 16'd1;
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MSP            = r_msp;
  assign RSP            = r_rsp;
  // The read port serves the return stack only while a RetPop is in flight.
  assign MemDst1FromMSP = (r_state != IDLE && r_op == OP_RPOP) ? r_rsp : r_msp;
  assign MemDst2FromMSP = r_msp - 16'd1;
  assign MemDst2FromRSP = r_rsp - 16'd1;
  assign MemDst1        = r_memDst1;
  assign MemDst2        = r_memDst2;
  assign MemRead1       = r_memRead1;
  assign MemWrite2      = r_memWrite2;
  assign Busy           = r_busy;
  assign Done           = r_done;
  assign Overflow       = r_overflow;
  assign Underflow      = r_underflow;
  assign BadOp          = r_badOp;

endmodule
`default_nettype wire

// File: tb/tb_stack_pointer_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stack_pointer_unit                                           |
// | Purpose  : directed vector bench for stack_pointer_unit                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_stack_pointer_unit;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] MPU  = 5'b00001;
  localparam logic [4:0] MPO  = 5'b00010;
  localparam logic [4:0] RPU  = 5'b00100;
  localparam logic [4:0] RPO  = 5'b01000;
  localparam logic [4:0] LD   = 5'b10000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        MainPush = 1'b0, MainPop = 1'b0, RetPush = 1'b0, RetPop = 1'b0;
  logic        LoadMSP = 1'b0, ClearErr = 1'b0;
  logic [15:0] LoadValue = 16'd0;
  logic [15:0] MSP, RSP, MemDst1FromMSP, MemDst2FromMSP, MemDst2FromRSP;
  logic [1:0]  MemDst1, MemDst2;
  logic        MemRead1, MemWrite2, Busy, Done, Overflow, Underflow, BadOp;

  int nChecks = 0;
  int nFail   = 0;

  stack_pointer_unit dut (
    .CLK(CLK), .RST_N(RST_N),
    .MainPush(MainPush), .MainPop(MainPop), .RetPush(RetPush), .RetPop(RetPop),
    .LoadMSP(LoadMSP), .LoadValue(LoadValue), .ClearErr(ClearErr),
    .MSP(MSP), .RSP(RSP),
    .MemDst1FromMSP(MemDst1FromMSP), .MemDst2FromMSP(MemDst2FromMSP),
    .MemDst2FromRSP(MemDst2FromRSP),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemRead1(MemRead1), .MemWrite2(MemWrite2),
    .Busy(Busy), .Done(Done), .Overflow(Overflow), .Underflow(Underflow), .BadOp(BadOp)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  req;
    logic        clr;
    logic [15:0] loadVal;
    logic        expWr;
    logic        expRd;
    logic [15:0] expAddr;
    logic [1:0]  expSel1;
    logic [1:0]  expSel2;
    int          expDone;
    logic [15:0] expMsp;
    logic [15:0] expRsp;
    logic [2:0]  expFlags;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [4:0] req, input logic clr, input logic [15:0] lv,
                              input logic wr, input logic rd, input logic [15:0] addr,
                              input logic [1:0] s1, input logic [1:0] s2, input int dn,
                              input logic [15:0] msp, input logic [15:0] rsp,
                              input logic [2:0] fl);
    vec_t v;
    v.req = req; v.clr = clr; v.loadVal = lv; v.expWr = wr; v.expRd = rd;
    v.expAddr = addr; v.expSel1 = s1; v.expSel2 = s2; v.expDone = dn;
    v.expMsp = msp; v.expRsp = rsp; v.expFlags = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic driveReq(input logic [4:0] req, input logic clr, input logic [15:0] lv);
    MainPush  = req[0];
    MainPop   = req[1];
    RetPush   = req[2];
    RetPop    = req[3];
    LoadMSP   = req[4];
    ClearErr  = clr;
    LoadValue = lv;
  endtask

  initial begin
    logic        wr, rd, busy1;
    logic [15:0] addr;
    logic [1:0]  sel1, sel2;
    int          doneCnt, strobeCnt;

    // {req, clr, LoadValue, wr, rd, addr, MemDst1, MemDst2, Done pulses, MSP, RSP, {Ovf,Unf,Bad}}
    vecs[0]  = mk(MPU,       0, 0,    1, 0, 4094, 0, 0, 1, 4094, 8191, 3'b000);
    vecs[1]  = mk(MPU,       0, 0,    1, 0, 4093, 0, 0, 1, 4093, 8191, 3'b000);
    vecs[2]  = mk(MPU,       0, 0,    1, 0, 4092, 0, 0, 1, 4092, 8191, 3'b000);
    vecs[3]  = mk(MPO,       0, 0,    0, 1, 4092, 1, 0, 1, 4093, 8191, 3'b000);
    vecs[4]  = mk(MPO,       0, 0,    0, 1, 4093, 1, 0, 1, 4094, 8191, 3'b000);
    vecs[5]  = mk(MPO,       0, 0,    0, 1, 4094, 1, 0, 1, 4095, 8191, 3'b000);
    vecs[6]  = mk(MPO,       0, 0,    0, 0, 0,    0, 0, 0, 4095, 8191, 3'b010);
    vecs[7]  = mk(NONE,      1, 0,    0, 0, 0,    0, 0, 0, 4095, 8191, 3'b000);
    vecs[8]  = mk(LD,        0, 3071, 0, 0, 0,    0, 0, 1, 3071, 8191, 3'b000);
    vecs[9]  = mk(MPU,       0, 0,    0, 0, 0,    0, 0, 0, 3071, 8191, 3'b100);
    vecs[10] = mk(NONE,      1, 0,    0, 0, 0,    0, 0, 0, 3071, 8191, 3'b000);
    vecs[11] = mk(LD,        0, 4095, 0, 0, 0,    0, 0, 1, 4095, 8191, 3'b000);
    vecs[12] = mk(MPU | RPU, 0, 0,    0, 0, 0,    0, 0, 0, 4095, 8191, 3'b001);
    vecs[13] = mk(RPU,       0, 0,    1, 0, 8190, 0, 1, 1, 4095, 8190, 3'b001);
    vecs[14] = mk(RPO,       0, 0,    0, 1, 8190, 1, 0, 1, 4095, 8191, 3'b001);
    vecs[15] = mk(RPO,       0, 0,    0, 0, 0,    0, 0, 0, 4095, 8191, 3'b011);
    vecs[16] = mk(MPO,       1, 0,    0, 0, 0,    0, 0, 0, 4095, 8191, 3'b010);
    vecs[17] = mk(NONE,      1, 0,    0, 0, 0,    0, 0, 0, 4095, 8191, 3'b000);

    repeat (2) @(posedge CLK);
    #1;
    check("reset MSP", 32'(MSP), 32'd4095);
    check("reset RSP", 32'(RSP), 32'd8191);
    check("reset strobes", {30'd0, MemRead1, MemWrite2}, 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("post-reset MSP", 32'(MSP), 32'd4095);
    check("post-reset RSP", 32'(RSP), 32'd8191);
    check("post-reset Busy/Done", {30'd0, Busy, Done}, 32'd0);
    check("post-reset flags", {29'd0, Overflow, Underflow, BadOp}, 32'd0);
    check("post-reset MemDst2FromMSP", 32'(MemDst2FromMSP), 32'd4094);
    check("post-reset MemDst2FromRSP", 32'(MemDst2FromRSP), 32'd8190);

    for (int i = 0; i < 18; i++) begin
      @(posedge CLK); #1;
      driveReq(vecs[i].req, vecs[i].clr, vecs[i].loadVal);
      @(posedge CLK); #1;
      driveReq(NONE, 1'b0, 16'd0);
      wr = MemWrite2; rd = MemRead1; busy1 = Busy; sel1 = MemDst1; sel2 = MemDst2;
      addr = 16'd0;
      if (MemWrite2) addr = (MemDst2 == 2'd1) ? MemDst2FromRSP : MemDst2FromMSP;
      else if (MemRead1) addr = MemDst1FromMSP;
      doneCnt   = int'(Done);
      strobeCnt = int'(MemWrite2 | MemRead1);
      for (int c = 0; c < 2; c++) begin
        @(posedge CLK); #1;
        doneCnt   += int'(Done);
        strobeCnt += int'(MemWrite2 | MemRead1);
      end
      check($sformatf("v%0d MemWrite2", i), {31'd0, wr}, {31'd0, vecs[i].expWr});
      check($sformatf("v%0d MemRead1", i), {31'd0, rd}, {31'd0, vecs[i].expRd});
      check($sformatf("v%0d Busy", i), {31'd0, busy1}, {31'd0, vecs[i].expWr | vecs[i].expRd});
      check($sformatf("v%0d addr", i), 32'(addr), 32'(vecs[i].expAddr));
      check($sformatf("v%0d MemDst1", i), 32'(sel1), 32'(vecs[i].expSel1));
      check($sformatf("v%0d MemDst2", i), 32'(sel2), 32'(vecs[i].expSel2));
      check($sformatf("v%0d strobe cycles", i), 32'(strobeCnt),
            (vecs[i].expWr | vecs[i].expRd) ? 32'd2 : 32'd0);
      check($sformatf("v%0d Done pulses", i), 32'(doneCnt), 32'(vecs[i].expDone));
      check($sformatf("v%0d MSP", i), 32'(MSP), 32'(vecs[i].expMsp));
      check($sformatf("v%0d RSP", i), 32'(RSP), 32'(vecs[i].expRsp));
      check($sformatf("v%0d flags", i), {29'd0, Overflow, Underflow, BadOp},
            {29'd0, vecs[i].expFlags});
    end

    // Back-to-back pushes: second request presented on the cycle after ACC2.
    @(posedge CLK); #1;
    driveReq(MPU, 1'b0, 16'd0);
    @(posedge CLK); #1;
    check("b2b first ACC1 write", {31'd0, MemWrite2}, 32'd1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("b2b idle gap Busy", {31'd0, Busy}, 32'd0);
    @(posedge CLK); #1;
    driveReq(NONE, 1'b0, 16'd0);
    check("b2b second addr", 32'(MemDst2FromMSP), 32'd4093);
    check("b2b second write", {31'd0, MemWrite2}, 32'd1);
    repeat (2) @(posedge CLK);
    #1;
    check("b2b final MSP", 32'(MSP), 32'd4093);

    // Reset during ACC2 of a push aborts it without a pointer update.
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    driveReq(MPU, 1'b0, 16'd0);
    @(posedge CLK); #1;
    driveReq(NONE, 1'b0, 16'd0);
    check("abort ACC1 write", {31'd0, MemWrite2}, 32'd1);
    @(posedge CLK); #1;
    check("abort ACC2 Busy", {31'd0, Busy}, 32'd1);
    RST_N = 1'b0;
    #1;
    check("abort MemWrite2 drop", {31'd0, MemWrite2}, 32'd0);
    check("abort Busy/Done drop", {30'd0, Busy, Done}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    doneCnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      doneCnt += int'(Done);
    end
    check("abort no Done", 32'(doneCnt), 32'd0);
    check("abort MSP", 32'(MSP), 32'd4095);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
